addsub_seq: RTL and testbench

//  Parametrised multi-cycle two's-complement add/subtract unit. Successor to the fixed 4-bit add/sub cells.

---
 rtl/addsub_pkg.sv | 17 +
 rtl/addsub_chunk.sv | 23 ++
 rtl/addsub_seq.sv | 106 ++++++++++
 tb/tb_addsub_seq.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// addsub_pkg: shared state encoding, op codes and chunk-count helper for the sequential add/sub unit
package addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int chunk_count(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/addsub_chunk.sv
// addsub_chunk: combinational CHUNK-bit ripple slice built from per-bit full adders
module addsub_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[CHUNK];

endmodule

// File: rtl/addsub_seq.sv
// addsub_seq: multi-cycle add/subtract, CHUNK bits per clock through one shared slice; ADDSUB_SAT_EN enables signed saturation
module addsub_seq
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    localparam int N  = chunk_count(WIDTH, CHUNK);
    localparam int IW = N > 1 ? $clog2(N) : 1;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_q, b_q, raw_q, raw_next, final_val;
    logic [CHUNK-1:0] slice_a, slice_b, sum;
    logic [IW-1:0]    idx;
    logic             sub_q, cin_q, cout, last, accept, ovf_raw;
    int               sh;

    assign in_ready  = state == ST_IDLE;
    assign out_valid = state == ST_DONE;
    assign accept    = in_valid & in_ready;
    assign last      = idx == IW'(N - 1);
    assign sh        = int'(idx) * CHUNK;
    assign slice_a   = CHUNK'(a_q >> sh);
    assign slice_b   = CHUNK'(b_q >> sh);

    addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (cin_q),
        .sum  (sum),
        .cout (cout)
    );

    // merge the current slice sum into the raw result and derive the final value
    always_comb begin
        raw_next = (raw_q & ~(WIDTH'({CHUNK{1'b1}}) << sh)) | (WIDTH'(sum) << sh);
        ovf_raw  = (a_q[WIDTH-1] == b_q[WIDTH-1]) & (raw_next[WIDTH-1] != a_q[WIDTH-1]);
`ifdef ADDSUB_SAT_EN
        final_val = ovf_raw ? {a_q[WIDTH-1], {(WIDTH-1){~a_q[WIDTH-1]}}} : raw_next;
`else
        final_val = raw_next;
`endif
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // next state: accept, N calc cycles, hold until consumer takes the result
    always_comb begin
        state_next = state == ST_IDLE ? (accept ? ST_CALC : ST_IDLE) :
                     state == ST_CALC ? (last ? ST_DONE : ST_CALC) :
                     state == ST_DONE ? (out_ready ? ST_IDLE : ST_DONE) : ST_IDLE;
    end

    // operand capture, per-chunk accumulation and final flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            raw_q    <= '0;
            sub_q    <= 1'b0;
            cin_q    <= 1'b0;
            idx      <= '0;
            result   <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else if (accept) begin
            a_q   <= a;
            b_q   <= b ^ {WIDTH{sub == OP_SUB}};
            sub_q <= sub;
            cin_q <= sub;
            raw_q <= '0;
            idx   <= '0;
        end else if (state == ST_CALC) begin
            raw_q <= raw_next;
            cin_q <= cout;
            idx   <= last ? '0 : idx + 1'b1;
            if (last) begin
                result   <= final_val;
                carry    <= cout ^ sub_q;
                overflow <= ovf_raw;
                zero     <= final_val == '0;
            end
        end
    end

endmodule

// File: tb/tb_addsub_seq.sv
// tb_addsub_seq: directed vectors with literal expectations plus a per-cycle arithmetic reference model
module tb_addsub_seq;
    import addsub_pkg::*;

    localparam int W = 16;
    localparam int C = 4;
    localparam int N = chunk_count(W, C);
`ifdef ADDSUB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk = 1'b0, rst = 1'b1, in_valid = 1'b0, sub = 1'b0, out_ready = 1'b1;
    logic         in_ready, out_valid, carry, overflow, zero;
    logic [W-1:0] a = '0, b = '0, result;

    int errors = 0, checks = 0, ncyc = 0;

    bit           busy = 1'b0;
    int           done_at = 0;
    logic [W-1:0] m_result = '0, p_result = '0;
    logic         m_carry = 1'b0, m_ovf = 1'b0, m_zero = 1'b0;
    logic         p_carry = 1'b0, p_ovf = 1'b0, p_zero = 1'b0;

    always #5 clk = ~clk;

    addsub_seq #(.WIDTH(W), .CHUNK(C)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .overflow  (overflow),
        .zero      (zero)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // reference model: plain signed/unsigned integer arithmetic, advanced and compared every negedge
    always @(negedge clk) begin : compare
        logic exp_valid;
        int   sa, sb, r;
        ncyc++;
        exp_valid = busy && ncyc >= done_at;
        if (exp_valid && ncyc == done_at) begin
            m_result = p_result;
            m_carry  = p_carry;
            m_ovf    = p_ovf;
            m_zero   = p_zero;
        end
        check("out_valid", out_valid, exp_valid);
        check("in_ready", in_ready, !busy);
        check("result", result, m_result);
        check("carry", carry, m_carry);
        check("overflow", overflow, m_ovf);
        check("zero", zero, m_zero);
        if (rst) begin
            busy     = 1'b0;
            m_result = '0;
            m_carry  = 1'b0;
            m_ovf    = 1'b0;
            m_zero   = 1'b0;
        end else if (exp_valid && out_ready) begin
            busy = 1'b0;
        end else if (!busy && in_valid) begin
            busy     = 1'b1;
            done_at  = ncyc + N + 1;
            sa       = int'($signed(a));
            sb       = int'($signed(b));
            r        = sub ? sa - sb : sa + sb;
            p_ovf    = r > 32767 || r < -32768;
            p_carry  = sub ? (int'(a) < int'(b)) : (int'(a) + int'(b) > 65535);
            p_result = (SAT && p_ovf) ? (a[W-1] ? 16'h8000 : 16'h7FFF) : W'(r);
            p_zero   = p_result == '0;
        end
    end

    task automatic op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                      input logic [W-1:0] er, input logic ec, input logic eo, input logic ez, input int stall);
        int t;
        a = x;
        b = y;
        sub = s;
        in_valid = 1'b1;
        out_ready = stall == 0;
        t = 0;
        while (!in_ready && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        check({tag, " in_ready"}, in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        sub = 1'($urandom);
        t = 0;
        while (!out_valid && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        check({tag, " out_valid"}, out_valid, 1'b1);
        check({tag, " result"}, result, er);
        check({tag, " carry"}, carry, ec);
        check({tag, " overflow"}, overflow, eo);
        check({tag, " zero"}, zero, ez);
        if (stall > 0) begin
            repeat (stall) begin
                @(posedge clk); #1;
            end
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        op("add_basic", 16'h1234, 16'h0001, OP_ADD, 16'h1235, 1'b0, 1'b0, 1'b0, 0);
        op("sub_borrow", 16'h0003, 16'h0005, OP_SUB, 16'hFFFE, 1'b1, 1'b0, 1'b0, 0);
        op("add_ovf", 16'h7FFF, 16'h0001, OP_ADD, SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b1, 1'b0, 0);
        op("add_wrap", 16'hFFFF, 16'h0001, OP_ADD, 16'h0000, 1'b1, 1'b0, 1'b1, 0);
        op("sub_ovf", 16'h8000, 16'h0001, OP_SUB, SAT ? 16'h8000 : 16'h7FFF, 1'b0, 1'b1, 1'b0, 0);
        op("add_negovf", 16'h8000, 16'h8000, OP_ADD, SAT ? 16'h8000 : 16'h0000, 1'b1, 1'b1, !SAT, 0);
        op("sub_equal", 16'h0005, 16'h0005, OP_SUB, 16'h0000, 1'b0, 1'b0, 1'b1, 0);
        op("add_stall", 16'h00FF, 16'h0F01, OP_ADD, 16'h1000, 1'b0, 1'b0, 1'b0, 5);
        a = 16'h4321;
        b = 16'h1111;
        sub = OP_SUB;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort in_ready", in_ready, 1'b1);
        check("abort out_valid", out_valid, 1'b0);
        check("abort result", result, 16'h0000);
        op("after_abort", 16'h4321, 16'h1111, OP_SUB, 16'h3210, 1'b0, 1'b0, 1'b0, 0);
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
